// File: rtl/ttt_turn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ttt_turn_ctrl_if
// Description : Move-request handshake between player input logic and the
//               tic-tac-toe turn controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ttt_turn_ctrl_if;
    logic       mv_valid;
    logic       mv_player;
    logic [3:0] mv_cell;
    logic       mv_ready;
    logic       mv_ack;
    logic       mv_err;

    modport master (
        output mv_valid, mv_player, mv_cell,
        input  mv_ready, mv_ack, mv_err
    );

    modport slave (
        input  mv_valid, mv_player, mv_cell,
        output mv_ready, mv_ack, mv_err
    );
endinterface
`default_nettype wire

// File: rtl/ttt_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ttt_turn_ctrl
// Description : Tic-tac-toe sequencing controller: owns the board, validates
//               moves against the parity-derived turn, detects win/draw.
//               Optional per-turn forfeit timer built when TTT_TIMEOUT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_turn_ctrl #(
    parameter int TIMEOUT = 1000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    ttt_turn_ctrl_if.slave   mv,
    output logic [18:1]      board,
    output logic [2:1]       turn,
    output logic [2:1]       winner,
    output logic             draw,
    output logic             game_over,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Cell k occupies bits {2k+1, 2k}; bit 0 of a cell is P1, bit 1 is P2.
    localparam logic [8:0] c_lines [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_board;
    logic [17:0] w_board_nxt;
    logic        r_ack,   w_ack_nxt;
    logic        r_err,   w_err_nxt;
    logic [1:0]  r_winner, w_winner_nxt;
    logic        r_draw,  w_draw_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        r_last,  w_last_nxt;
    logic        r_ready;
    logic        r_game_over;

    logic        w_parity;
    logic [8:0]  w_occ;
    logic [8:0]  w_plane;
    logic        w_win;
    logic        w_cell_ok;
    logic        w_legal;
    logic        w_cnt_hit;

    assign w_parity = ^r_board;

    always_comb begin
        w_win = 1'b0;
        for (int k = 0; k < 9; k++) begin
            w_occ[k]   = r_board[2*k] | r_board[2*k+1];
            w_plane[k] = r_last ? r_board[2*k+1] : r_board[2*k];
        end
        for (int l = 0; l < 8; l++) begin
            if ((w_plane & c_lines[l]) == c_lines[l]) begin
                w_win = 1'b1;
            end
        end
    end

    assign w_cell_ok = (mv.mv_cell <= 4'd8) && !w_occ[mv.mv_cell];
    assign w_legal   = mv.mv_valid && w_cell_ok && (mv.mv_player == w_parity);

`ifdef TTT_TIMEOUT_EN
    logic [15:0] r_cnt;

    assign w_cnt_hit = (17'(r_cnt) + 17'd1) == 17'(TIMEOUT);

    // Restart the count on every fresh entry to WAIT, including a restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (w_state_nxt == S_WAIT && (r_state != S_WAIT || start)) begin
            r_cnt <= 16'd0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_cnt_hit        = 1'b0;
    assign w_unused_timeout = ^16'(TIMEOUT);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_board_nxt   = r_board;
        w_ack_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_winner_nxt  = r_winner;
        w_draw_nxt    = r_draw;
        w_timeout_nxt = r_timeout;
        w_last_nxt    = r_last;

        if (start) begin
            w_state_nxt   = S_WAIT;
            w_board_nxt   = 18'd0;
            w_winner_nxt  = 2'b00;
            w_draw_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_legal) begin
                        w_board_nxt[{mv.mv_cell, mv.mv_player}] = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_last_nxt  = mv.mv_player;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_err_nxt = mv.mv_valid;
                        if (w_cnt_hit) begin
                            // Forfeit: the player who failed to move loses.
                            w_state_nxt   = S_DONE;
                            w_winner_nxt  = w_parity ? 2'b01 : 2'b10;
                            w_timeout_nxt = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_win) begin
                        w_winner_nxt = r_last ? 2'b10 : 2'b01;
                        w_state_nxt  = S_DONE;
                    end else if (&w_occ) begin
                        w_draw_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_board     <= 18'd0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_winner    <= 2'b00;
            r_draw      <= 1'b0;
            r_timeout   <= 1'b0;
            r_last      <= 1'b0;
            r_ready     <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_board     <= w_board_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_winner    <= w_winner_nxt;
            r_draw      <= w_draw_nxt;
            r_timeout   <= w_timeout_nxt;
            r_last      <= w_last_nxt;
            r_ready     <= (w_state_nxt == S_WAIT);
            r_game_over <= (w_state_nxt == S_DONE);
        end
    end

    assign board       = r_board;
    assign turn        = w_parity ? 2'b10 : 2'b01;
    assign winner      = r_winner;
    assign draw        = r_draw;
    assign game_over   = r_game_over;
    assign timeout     = r_timeout;
    assign mv.mv_ready = r_ready;
    assign mv.mv_ack   = r_ack;
    assign mv.mv_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ttt_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_turn_ctrl
// Description : Self-checking bench for ttt_turn_ctrl against a cell-array
//               game model; directed scenarios then random play.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_turn_ctrl;

    localparam int c_timeout = 10;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CHECK = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [18:1] board;
    logic [2:1]  turn;
    logic [2:1]  winner;
    logic        draw;
    logic        game_over;
    logic        timeout;

    ttt_turn_ctrl_if u_if ();

    ttt_turn_ctrl #(.TIMEOUT(c_timeout)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mv        (u_if.slave),
        .board     (board),
        .turn      (turn),
        .winner    (winner),
        .draw      (draw),
        .game_over (game_over),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Game model: cell contents 0 = empty, 1 = P1, 2 = P2.
    int m_cell[9];
    int m_mode, m_winner, m_last, m_wcnt;
    bit m_ack, m_err, m_draw, m_to;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic int marks();
        int n = 0;
        for (int k = 0; k < 9; k++) if (m_cell[k] != 0) n++;
        return n;
    endfunction

    function automatic bit has_line(input int who);
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who &&
                m_cell[lines[l][2]] == who) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] exp_board();
        logic [17:0] b = '0;
        for (int k = 0; k < 9; k++) begin
            if (m_cell[k] == 1) b[2*k]   = 1'b1;
            if (m_cell[k] == 2) b[2*k+1] = 1'b1;
        end
        return b;
    endfunction

    function automatic bit is_legal(input bit v, input bit p, input logic [3:0] c);
        if (!v || c > 4'd8) return 1'b0;
        if (m_cell[c] != 0) return 1'b0;
        return (int'(p) == marks() % 2);
    endfunction

    task automatic model_step(input bit v, input bit p, input logic [3:0] c,
                              input bit s, input bit r);
        bit legal;
        if (r) begin
            foreach (m_cell[k]) m_cell[k] = 0;
            m_mode = M_IDLE; m_winner = 0; m_ack = 0; m_err = 0;
            m_draw = 0; m_to = 0; m_last = 0; m_wcnt = 0;
            return;
        end
        m_ack = 0;
        m_err = 0;
        if (s) begin
            foreach (m_cell[k]) m_cell[k] = 0;
            m_winner = 0; m_draw = 0; m_to = 0; m_wcnt = 0;
            m_mode = M_WAIT;
            return;
        end
        case (m_mode)
            M_WAIT: begin
                legal = is_legal(v, p, c);
                m_wcnt++;
                if (legal) begin
                    m_cell[c] = int'(p) + 1;
                    m_last = int'(p) + 1;
                    m_ack = 1;
                    m_mode = M_CHECK;
                end else begin
                    m_err = v;
`ifdef TTT_TIMEOUT_EN
                    if (m_wcnt == c_timeout) begin
                        m_mode = M_DONE;
                        m_winner = (marks() % 2 == 0) ? 2 : 1;
                        m_to = 1;
                    end
`endif
                end
            end
            M_CHECK: begin
                if (has_line(m_last)) begin
                    m_winner = m_last;
                    m_mode = M_DONE;
                end else if (marks() == 9) begin
                    m_draw = 1;
                    m_mode = M_DONE;
                end else begin
                    m_mode = M_WAIT;
                    m_wcnt = 0;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [7:0] exp_flags();
        return {m_mode == M_WAIT, m_ack, m_err, 2'(m_winner), m_draw,
                m_mode == M_DONE, m_to};
    endfunction

    task automatic do_cycle(input bit v, input bit p, input logic [3:0] c,
                            input bit s, input bit r);
        u_if.mv_valid  = v;
        u_if.mv_player = p;
        u_if.mv_cell   = c;
        start = s;
        rst   = r;
        @(posedge clk);
        model_step(v, p, c, s, r);
        #1;
        chk("board", 32'(board), 32'(exp_board()));
        chk("turn", 32'(turn), (marks() % 2 == 0) ? 32'd1 : 32'd2);
        chk("flags", 32'({u_if.mv_ready, u_if.mv_ack, u_if.mv_err, winner,
                          draw, game_over, timeout}), 32'(exp_flags()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic play(input bit p, input logic [3:0] c);
        do_cycle(1'b1, p, c, 1'b0, 1'b0);
        idle(1);
    endtask

    initial begin
        int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        u_if.mv_valid = 0; u_if.mv_player = 0; u_if.mv_cell = 0;
        start = 0; rst = 1;

        do_cycle(0, 0, 0, 0, 1);
        do_cycle(0, 0, 0, 0, 1);
        chk("rst_outs", 32'({u_if.mv_ready, u_if.mv_ack, u_if.mv_err, winner,
                             draw, game_over, timeout}), 32'd0);
        chk("rst_turn", 32'(turn), 32'd1);
        idle(2);
        chk("idle_ready", 32'(u_if.mv_ready), 32'd0);

        // First move and its latency to the next ready.
        do_cycle(0, 0, 0, 1, 0);
        chk("start_ready", 32'(u_if.mv_ready), 32'd1);
        do_cycle(1, 0, 4'd4, 0, 0);
        chk("p1c4_board", 32'(board), 32'h00100);
        chk("p1c4_turn", 32'(turn), 32'd2);
        chk("p1c4_ack", 32'(u_if.mv_ack), 32'd1);
        chk("check_ready", 32'(u_if.mv_ready), 32'd0);
        idle(1);
        chk("ready_2cyc", 32'(u_if.mv_ready), 32'd1);

        // Illegal moves: occupied cell, wrong player, cell out of range.
        do_cycle(1, 1, 4'd4, 0, 0);
        chk("err_occ", 32'({u_if.mv_err, u_if.mv_ready}), 32'd3);
        do_cycle(1, 0, 4'd0, 0, 0);
        chk("err_turn", 32'(u_if.mv_err), 32'd1);
        do_cycle(1, 1, 4'd9, 0, 0);
        chk("err_cell", 32'(u_if.mv_err), 32'd1);
        chk("err_board", 32'(board), 32'h00100);

        // P1 wins on the top row.
        do_cycle(0, 0, 0, 1, 0);
        play(0, 0); play(1, 3); play(0, 1); play(1, 4);
        do_cycle(1, 0, 4'd2, 0, 0);
        chk("win_notyet", 32'(game_over), 32'd0);
        idle(1);
        chk("win_winner", 32'(winner), 32'd1);
        chk("win_over", 32'(game_over), 32'd1);
        do_cycle(1, 1, 4'd5, 0, 0);
        chk("done_ignore", 32'({u_if.mv_ack, u_if.mv_err}), 32'd0);

        // Full board, no line.
        do_cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) play(i[0], 4'(draw_seq[i]));
        chk("draw_flag", 32'({draw, winner, game_over}), 32'b1001);
        chk("draw_board", 32'(board), 32'h16A59);

        // start beats a simultaneous move; rst aborts mid-game.
        do_cycle(1, 0, 4'd4, 1, 0);
        chk("start_prio", 32'({u_if.mv_ack, u_if.mv_err, 18'(board)}), 32'd0);
        play(0, 0); play(1, 1);
        do_cycle(1, 0, 4'd2, 0, 1);
        chk("rst_mid", 32'({u_if.mv_ready, u_if.mv_ack, 18'(board)}), 32'd0);
        do_cycle(0, 0, 0, 1, 0);
        chk("restart", 32'({u_if.mv_ready, 18'(board)}), 32'h40000);

`ifdef TTT_TIMEOUT_EN
        idle(c_timeout);
        chk("to_flag", 32'({timeout, winner}), 32'b110);
        do_cycle(0, 0, 0, 1, 0);
        idle(c_timeout - 1);
        do_cycle(1, 0, 4'd4, 0, 0);
        chk("to_race", 32'({u_if.mv_ack, timeout}), 32'b10);
`endif

        // Random play, mostly legal moves, with occasional restarts/resets.
        for (int n = 0; n < 2000; n++) begin
            bit v, p, s, r;
            logic [3:0] c;
            r = ($urandom_range(0, 399) == 0);
            s = (m_mode == M_DONE) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 79) == 0);
            if (m_mode == M_IDLE) s = ($urandom_range(0, 2) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = 1'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 15));
            if (m_mode == M_WAIT && $urandom_range(0, 9) < 7) begin
                int e;
                p = 1'(marks() % 2);
                e = $urandom_range(0, 8);
                while (m_cell[e] != 0) e = (e + 1) % 9;
                c = 4'(e);
            end
            do_cycle(v, p, c, s, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
